// File: rtl/algorithmic_multiplier.sv
// Iterative radix-2 shift-and-add unsigned multiplier.
// Computes one partial product per clock, so an N x N multiply takes N cycles.
module algorithmic_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rstN,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] result,
  output logic           busy,
  output logic           done
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t         state;
  logic [2*N-1:0] mcand;
  logic [2*N-1:0] acc;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  count;
  logic [2*N-1:0] acc_next;

  // Accumulator value including this cycle's partial product; the last
  // iteration writes it straight to result.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state  <= IDLE;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      count  <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= {{N{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            count  <= CW'(N);
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - 1'b1;
          // Fixed latency: no early exit when mplier runs out of ones.
          if (count == CW'(1)) begin
            result <= acc_next;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_algorithmic_multiplier.sv
// Scoreboard bench for algorithmic_multiplier: expected products are queued
// when a start is accepted and compared on every done pulse.
module tb_algorithmic_multiplier;

  localparam int N = 8;

  typedef struct {
    logic [2*N-1:0] prod;
    int             t_acc;
  } exp_t;

  logic           clk;
  logic           rstN;
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic [2*N-1:0] result;
  logic           busy;
  logic           done;

  int   checks;
  int   failures;
  int   cyc;
  int   ndone;
  int   last_done_cyc;
  logic prev_done;
  exp_t q[$];

  algorithmic_multiplier #(.N(N)) dut (
    .clk    (clk),
    .rstN   (rstN),
    .start  (start),
    .a      (a),
    .b      (b),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: every done must match the oldest pending operation.
  always @(negedge clk) begin
    if (rstN && done) begin
      check("done_pulse_width", {31'b0, prev_done}, 0);
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("result", {16'b0, result}, {16'b0, e.prod});
        check("latency", cyc - e.t_acc, N);
        check("busy_at_done", {31'b0, busy}, 0);
      end
      ndone++;
      last_done_cyc = cyc;
    end
    prev_done = done;
  end

  task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y);
    exp_t e;
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.prod  = (2*N)'(x) * (2*N)'(y);
    e.t_acc = cyc;
    q.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    int n0;
    n0 = ndone;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (ndone != n0) return;
    end
    check("done_timeout", 0, 1);
  endtask

  task automatic op(input logic [N-1:0] x, input logic [N-1:0] y);
    issue(x, y);
    wait_done(3 * N);
    @(negedge clk);
    check("done_low_after", {31'b0, done}, 0);
    check("busy_low_after", {31'b0, busy}, 0);
  endtask

  initial begin
    int   n0;
    int   t1;
    exp_t e;
    checks = 0;
    failures = 0;
    cyc = 0;
    ndone = 0;
    last_done_cyc = 0;
    prev_done = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    rstN = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_result", {16'b0, result}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    rstN = 1'b1;
    @(negedge clk);

    // Basic op with busy visible during the run.
    issue(8'd4, 8'd2);
    @(negedge clk);
    check("busy_running", {31'b0, busy}, 1);
    wait_done(3 * N);
    @(negedge clk);
    check("done_low_after", {31'b0, done}, 0);
    check("busy_low_after", {31'b0, busy}, 0);

    op(8'd255, 8'd255);
    op(8'd0, 8'd173);
    op(8'd1, 8'd200);
    op(8'd173, 8'd0);

    // Operand changes and a start pulse while busy must not disturb the run.
    issue(8'd3, 8'd5);
    repeat (3) @(negedge clk);
    a = 8'd9;
    b = 8'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_mid_op", {31'b0, busy}, 1);
    wait_done(3 * N);
    n0 = ndone;
    repeat (2 * N) @(negedge clk);
    check("no_extra_done", ndone - n0, 0);

    // Back-to-back: start held high through the done cycle.
    @(negedge clk);
    a = 8'd6;
    b = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.prod = 16'd42;
    e.t_acc = cyc;
    q.push_back(e);
    a = 8'd11;
    b = 8'd13;
    begin
      int i;
      for (i = 0; i < 3 * N; i++) begin
        @(negedge clk);
        if (done) break;
      end
      if (i == 3 * N) check("b2b_first_timeout", 0, 1);
    end
    t1 = cyc;
    e.prod = 16'd143;
    e.t_acc = cyc + 1;
    q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("hold_first_result", {16'b0, result}, 42);
    wait_done(3 * N);
    check("b2b_gap", last_done_cyc - t1, N + 1);

    // Reset mid-run aborts without a done pulse.
    issue(8'd100, 8'd100);
    repeat (3) @(negedge clk);
    #2;
    rstN = 1'b0;
    #1;
    check("abort_result", {16'b0, result}, 0);
    check("abort_busy", {31'b0, busy}, 0);
    check("abort_done", {31'b0, done}, 0);
    q.delete();
    n0 = ndone;
    repeat (2 * N) @(negedge clk);
    check("abort_no_done", ndone - n0, 0);
    rstN = 1'b1;
    @(negedge clk);
    op(8'd12, 8'd34);

    // Random sweep.
    for (int k = 0; k < 1000; k++) begin
      issue(N'($urandom_range(0, 255)), N'($urandom_range(0, 255)));
      wait_done(3 * N);
    end
    repeat (2) @(negedge clk);
    check("queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/algorithmic_multiplier.md
Name: algorithmic_multiplier

Overview:
Iterative radix-2 shift-and-add unsigned multiplier: N-bit a × N-bit b -> 2N-bit product, one partial product per clock. Used where area matters more than latency; replaces a combinational array multiplier. Start/busy/done handshake; the product is held on result until the next operation completes.

Parameters:
N, 8, operand width in bits; result is 2N bits; iteration count equals N.

Ports:
clk  input  1  rising-edge clock
rstN  input  1  asynchronous active-low reset
start  input  1  request; sampled only when idle
a  input  N  multiplicand, unsigned
b  input  N  multiplier, unsigned
result  output  2N  product a*b of the last completed operation (registered)
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when result is updated

Behaviour:
- Reset (rstN low, async): result=0, busy=0, done=0, state=IDLE, internal registers cleared. Asserting reset mid-operation aborts it; no done pulse.
- States: IDLE, RUN.
- IDLE: done deasserts after 1 cycle. On an edge with start=1:
  - load mcand (2N bits) = zero-extended a; load mplier = b; clear acc (2N); count = N; busy<=1; go to RUN.
- RUN, each edge:
  - if mplier[0], acc += mcand (mod 2^2N; no overflow possible);
  - mcand <<= 1; mplier >>= 1; count -= 1.
  - On the edge where the Nth iteration executes: result <= final acc (including that iteration's add); done <= 1; busy <= 0; go to IDLE.
- Latency: start sampled at edge E -> result valid and done=1 after edge E+N. busy is high after E through edge E+N. Fixed latency; no early termination when mplier becomes 0.
- a and b are captured at start; later changes have no effect on the operation in flight.
- start while busy: ignored, not queued.
- Back-to-back: start may be high in the done cycle (state IDLE); the new operation is accepted then. done stays a single pulse per operation.
- result is unchanged from the end of one operation until the next done; not cleared at start.
- Arithmetic: unsigned only; result == a*b exactly for all 2^(2N) operand pairs.

Test Plan:
- Reset then a=4, b=2, start 1 cycle -> after 8 edges done=1 for 1 cycle, result=8, busy low afterwards.
- a=255, b=255 -> result=65025 (16'hFE01); a=0, b=173 -> 0; a=1, b=200 -> 200.
- Change a/b and pulse start mid-operation (a=3, b=5 running, then a=9, b=9 with start) -> result=15; second start ignored; a single done pulse.
- Back-to-back: start held high across the done cycle -> second product correct; done pulses separated by 9 cycles (8 RUN edges plus the accepting idle edge); result holds the first product until the second done.
- Assert rstN low mid-RUN -> result, busy, done go to 0 immediately; no done pulse; the next start works normally.
- Random sweep of 1000 operand pairs (plus exhaustive 8-bit if time allows) -> result === a*b on every done; done period == 8 cycles after start.
